inst_encoder: RTL
=================

Name: inst_encoder

Overview:
Streaming instruction encoder: the inverse of the CPU control decoder. Accepts symbolic instructions (op class, register fields, immediate) over a valid/ready handshake. Packs each into a 32-bit ARMv8-subset machine word and emits it, with a word address, toward instruction-memory load / testbench program builder. Buffered with a 2-entry output queue; the address counter advances per emitted word.

Parameters:
ADDR_W, 32, width of emitted instruction address
START_ADDR, 0, address of first emitted word after reset

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  instruction request valid
in_ready  output  1  encoder can accept request
in_op  input  4  op class (enum op_e in package)
in_rd  input  5  Rd / Rt field
in_rn  input  5  Rn field
in_rm  input  5  Rm field
in_imm  input  26  immediate, two's complement (unsigned for ADDI/LSL/LSR)
out_valid  output  1  encoded word valid
out_ready  input  1  consumer accepts word
out_word  output  32  encoded instruction
out_addr  output  ADDR_W  address of out_word
err  output  1  one-cycle pulse: request rejected
word_cnt  output  16  words emitted since reset

Behaviour:
- Reset (async): queue empty, out_valid=0, out_word=0, out_addr=START_ADDR, err=0, word_cnt=0, in_ready=1.
- Accept when in_valid && in_ready; in_ready = (queue occupancy < 2), independent of in_valid.
- Latency: word accepted at edge N is visible on out_valid/out_word at N+1 if the queue was empty (registered; no combinational in->out path).
- Pop when out_valid && out_ready. Then out_addr += 4 (wraps mod 2^ADDR_W) and word_cnt += 1 (wraps at 16 bits). Simultaneous push+pop at occupancy 1 keeps occupancy 1. Order is strictly FIFO.
- out_word/out_addr are stable while out_valid && !out_ready.
- Encodings ({msb..lsb}):
  - ADDI: 1001000100, imm[11:0], Rn, Rd
  - ADDS: 10101011000, Rm, 000000, Rn, Rd
  - SUBS: 11101011000, Rm, 000000, Rn, Rd
  - MUL: 10011011000, Rm, 011111, Rn, Rd
  - LSL: 11010011011, 00000, imm[5:0], Rn, Rd
  - LSR: 11010011010, 00000, imm[5:0], Rn, Rd
  - B: 000101, imm[25:0]
  - CBZ: 10110100, imm[18:0], Rd
  - B.LT: 01010100, imm[18:0], 01011
  - LDUR: 11111000010, imm[8:0], 00, Rn, Rd
  - STUR: 11111000000, imm[8:0], 00, Rn, Rd
- Unknown op code (enum value not listed): request consumed (handshake completes), nothing queued, err pulses the following cycle.
- Reset mid-stream: queue discarded, counters restored immediately.

Optional Feature:
INST_ENC_RANGE_CHECK_EN.
- Defined: immediates are range-checked:
  - ADDI 0..4095
  - LSL/LSR 0..63
  - CBZ/B.LT signed 19-bit
  - LDUR/STUR signed 9-bit
  - B always valid

  An out-of-range request is consumed, not queued, and err pulses, same as an unknown op.
- Undefined: immediates are silently truncated to field width; err only for unknown op.

Decomposition:
- Package inst_enc_pkg:
  - op_e enum (ADDI=0, ADDS, SUBS, MUL, LSL, LSR, B, CBZ, BLT, LDUR, STUR=10)
  - localparam opcode constants per class
  - COND_LT=4'b1011
- Sub-module inst_enc_fifo2: 2-entry {word, 32-bit} queue with valid/ready, instantiated once.
- Encoder packing is combinational logic in the top module.

Test Plan:
- ADDI rd=1 rn=2 imm=5, out_ready=1 -> next cycle out_valid=1, out_word=0x91001441, out_addr=0; word_cnt=1 after pop.
- B imm=-1 then CBZ rd=3 imm=2 then B.LT imm=4 -> words 0x17FFFFFF, 0xB4000043, 0x5400008B at addrs 0,4,8.
- LDUR rd=0 rn=1 imm=8; STUR rd=0 rn=0 imm=-1 -> 0xF8408020, 0xF81FF000.
- out_ready=0, push 3 requests -> in_ready=0 after 2 accepted; third held; out_word stable; release -> all three in order.
- ADDI imm=4096 with INST_ENC_RANGE_CHECK_EN -> err pulse, no word, word_cnt unchanged; without the macro -> word 0x91000041 for rd=1 rn=2.
- in_op=15 -> err pulse, no output; reset asserted with 2 queued -> out_valid=0, out_addr=START_ADDR asynchronously.

Source files
------------

// File: rtl/inst_enc_pkg.sv
// inst_enc_pkg: shared definitions for the instruction encoder.
//   op_e     - symbolic op class presented on in_op
//   OPC_*    - fixed opcode bit groups per op class (msb part of the word)
//   COND_LT  - condition code emitted in the low bits of B.LT
package inst_enc_pkg;

  typedef enum logic [3:0] {
    ADDI = 4'd0,
    ADDS = 4'd1,
    SUBS = 4'd2,
    MUL  = 4'd3,
    LSL  = 4'd4,
    LSR  = 4'd5,
    B    = 4'd6,
    CBZ  = 4'd7,
    BLT  = 4'd8,
    LDUR = 4'd9,
    STUR = 4'd10
  } op_e;

  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [10:0] OPC_ADDS = 11'b10101011000;
  localparam logic [10:0] OPC_SUBS = 11'b11101011000;
  localparam logic [10:0] OPC_MUL  = 11'b10011011000;
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_BCC  = 8'b01010100;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  // MUL is encoded as MADD with Ra = XZR.
  localparam logic [5:0]  MUL_RA   = 6'b011111;
  localparam logic [3:0]  COND_LT  = 4'b1011;

endpackage

// File: rtl/inst_enc_fifo2.sv
// inst_enc_fifo2: 2-entry registered FIFO of 32-bit words.
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid/in_ready    - push handshake; in_ready = occupancy < 2
//   in_data              - word to push
//   out_valid/out_ready  - pop handshake
//   out_data             - head word (zero when empty)
module inst_enc_fifo2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  logic [1:0][31:0] mem_q, mem_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: streaming symbolic-instruction to ARMv8-subset word encoder.
//   clk, reset            - clock, asynchronous active-high reset
//   in_valid/in_ready     - request handshake (in_ready = queue not full)
//   in_op/rd/rn/rm/imm    - symbolic instruction fields
//   out_valid/out_ready   - encoded word handshake
//   out_word, out_addr    - head word and its address (advances by 4 per pop)
//   err                   - one-cycle pulse after a rejected request
//   word_cnt              - words popped since reset (wraps at 16 bits)
// Build option: define INST_ENC_RANGE_CHECK_EN to reject out-of-range
// immediates instead of truncating them.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [25:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [15:0]       word_cnt
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic              err_q, err_d;

  logic [31:0] enc_word;
  logic        op_known;
  logic        imm_ok;
  logic        accept;
  logic        pop;
  op_e         op;

  assign op = op_e'(in_op);

  always_comb begin
    enc_word = '0;
    op_known = 1'b1;
    case (op)
      ADDI:    enc_word = {OPC_ADDI, in_imm[11:0], in_rn, in_rd};
      ADDS:    enc_word = {OPC_ADDS, in_rm, 6'b000000, in_rn, in_rd};
      SUBS:    enc_word = {OPC_SUBS, in_rm, 6'b000000, in_rn, in_rd};
      MUL:     enc_word = {OPC_MUL, in_rm, MUL_RA, in_rn, in_rd};
      LSL:     enc_word = {OPC_LSL, 5'b00000, in_imm[5:0], in_rn, in_rd};
      LSR:     enc_word = {OPC_LSR, 5'b00000, in_imm[5:0], in_rn, in_rd};
      B:       enc_word = {OPC_B, in_imm[25:0]};
      CBZ:     enc_word = {OPC_CBZ, in_imm[18:0], in_rd};
      BLT:     enc_word = {OPC_BCC, in_imm[18:0], 1'b0, COND_LT};
      LDUR:    enc_word = {OPC_LDUR, in_imm[8:0], 2'b00, in_rn, in_rd};
      STUR:    enc_word = {OPC_STUR, in_imm[8:0], 2'b00, in_rn, in_rd};
      default: op_known = 1'b0;
    endcase
  end

`ifdef INST_ENC_RANGE_CHECK_EN
  // Signed fields are in range when every bit above the field's sign bit
  // replicates that sign bit.
  always_comb begin
    imm_ok = 1'b1;
    case (op)
      ADDI:      imm_ok = (in_imm[25:12] == '0);
      LSL, LSR:  imm_ok = (in_imm[25:6] == '0);
      CBZ, BLT:  imm_ok = (in_imm[25:18] == {8{in_imm[18]}});
      LDUR, STUR: imm_ok = (in_imm[25:8] == {18{in_imm[8]}});
      default:   imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Rejected requests still complete the handshake but bypass the queue.
  inst_enc_fifo2 u_fifo (
    .clk       (clk),
    .rst       (reset),
    .in_valid  (in_valid && op_known && imm_ok),
    .in_ready  (in_ready),
    .in_data   (enc_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_word)
  );

  always_comb begin
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    err_d      = accept && !(op_known && imm_ok);
    if (pop) begin
      addr_d     = addr_q + ADDR_W'(4);
      word_cnt_d = word_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= START_ADDR;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
    end
  end

  assign out_addr = addr_q;
  assign word_cnt = word_cnt_q;
  assign err      = err_q;

endmodule
